// File: rtl/ready_sequencer_if.sv
// Handshake bundle between the ready sequencer and its requester/consumer.
// Latency n/a; start/ack are level-sampled, ready is held until ack or timeout.
interface ready_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             ack;
    logic             ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        output start,
        output ack,
        input  ready,
        input  busy,
        input  done,
        input  err,
        input  txn_cnt
    );

    modport slave (
        input  start,
        input  ack,
        output ready,
        output busy,
        output done,
        output err,
        output txn_cnt
    );
endinterface

// File: rtl/ready_sequencer.sv
// Raises a registered ready WAIT_CYCLES edges after start; holds it until ack or ACK_TIMEOUT.
// No backpressure: start is taken only in IDLE/ERR, ack only in READY, anything else is ignored.
module ready_sequencer #(
    parameter int WAIT_CYCLES = 4,
    parameter int ACK_TIMEOUT = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    ready_sequencer_if.slave bus
);

    localparam int WAIT_W = 8;
    localparam int HOLD_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   txn_q, txn_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Inputs are only read inside the states that sample them, so an X elsewhere never reaches state.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        txn_d   = txn_q;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                    state_d = ST_READY;
                    hold_d  = '0;
                    ready_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_READY: begin
                if (bus.ack) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    txn_d   = txn_q + 1'b1;
                end else if ((ACK_TIMEOUT != 0) && (hold_q == HOLD_W'(ACK_TIMEOUT - 1))) begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                    hold_d  = hold_q + 1'b1;
                end
            end
            ST_ERR: begin
                if (bus.start) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            hold_q  <= '0;
            txn_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
            txn_q   <= txn_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.txn_cnt = txn_q;

endmodule

// File: tb/tb_ready_sequencer.sv
// Directed bench for ready_sequencer: default instance plus a CNT_W=2 instance for wrap checks.
module tb_ready_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ready_sequencer_if #(.CNT_W(8)) bus ();
    ready_sequencer_if #(.CNT_W(2)) bus2 ();

    ready_sequencer #(.WAIT_CYCLES(4), .ACK_TIMEOUT(8), .CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ready_sequencer #(.WAIT_CYCLES(4), .ACK_TIMEOUT(8), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rise_cnt = 0;

    always @(posedge bus.ready) rise_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int t;
        int base;
        logic [1:0] wrap_exp [5];
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        bus.start  = 1'b0;
        bus.ack    = 1'b0;
        bus2.start = 1'b0;
        bus2.ack   = 1'b0;

        // Test 1: reset, single transaction
        rst = 1'b1;
        ticks(2);
        check("rst_ready", bus.ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_txn", bus.txn_cnt, 8'd0);
        rst = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t1_busy_wait", bus.busy, 1'b1);
        check("t1_ready_wait", bus.ready, 1'b0);
        ticks(3);
        check("t1_ready_early", bus.ready, 1'b0);
        tick();
        check("t1_ready_rise", bus.ready, 1'b1);
        tick();
        check("t1_ready_hold", bus.ready, 1'b1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t1_ready_fall", bus.ready, 1'b0);
        check("t1_done", bus.done, 1'b1);
        check("t1_busy_idle", bus.busy, 1'b0);
        check("t1_txn", bus.txn_cnt, 8'd1);
        tick();
        check("t1_done_pulse", bus.done, 1'b0);

        // Test 2: start held high, ack one cycle after each rise
        base = rise_cnt;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (!bus.ready && t < 20) begin
                tick();
                t++;
            end
            check("t2_latency", t, 5);
            check("t2_rises", rise_cnt, base + i + 1);
            bus.ack = 1'b1;
            tick();
            bus.ack = 1'b0;
            check("t2_done", bus.done, 1'b1);
            check("t2_txn", bus.txn_cnt, 8'(2 + i));
        end
        bus.start = 1'b0;
        ticks(6);
        check("t2_no_extra_rise", rise_cnt, base + 3);

        // Test 3: timeout, then recovery from ERR
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ticks(4);
        check("t3_ready", bus.ready, 1'b1);
        t = 0;
        while (bus.ready && t < 20) begin
            tick();
            t++;
        end
        check("t3_hold_cycles", t, 8);
        check("t3_err", bus.err, 1'b1);
        check("t3_busy", bus.busy, 1'b0);
        check("t3_done", bus.done, 1'b0);
        check("t3_txn", bus.txn_cnt, 8'd4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("t3_err_clr", bus.err, 1'b0);
        check("t3_busy2", bus.busy, 1'b1);
        ticks(3);
        check("t3_ready_early", bus.ready, 1'b0);
        tick();
        check("t3_ready_rise", bus.ready, 1'b1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t3_txn2", bus.txn_cnt, 8'd5);

        // Test 4: ack coincides with timeout edge; unknown inputs during WAIT
        bus.start = 1'b1;
        tick();
        bus.start = 1'bx;
        bus.ack   = 1'bx;
        ticks(2);
        bus.start = 1'b0;
        bus.ack   = 1'b0;
        ticks(2);
        check("t4_ready", bus.ready, 1'b1);
        ticks(7);
        check("t4_ready_late", bus.ready, 1'b1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check("t4_done", bus.done, 1'b1);
        check("t4_err", bus.err, 1'b0);
        check("t4_txn", bus.txn_cnt, 8'd6);

        // Test 5: reset during WAIT and during READY
        base = rise_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5w_ready", bus.ready, 1'b0);
        check("t5w_busy", bus.busy, 1'b0);
        check("t5w_done", bus.done, 1'b0);
        check("t5w_txn", bus.txn_cnt, 8'd0);
        ticks(6);
        check("t5w_no_rise", rise_cnt, base);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ticks(5);
        check("t5r_ready", bus.ready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5r_ready", bus.ready, 1'b0);
        check("t5r_busy", bus.busy, 1'b0);
        check("t5r_done", bus.done, 1'b0);
        ticks(6);
        check("t5r_no_rise", rise_cnt, base + 1);

        // Test 6: CNT_W=2 wrap, stray acks ignored
        bus2.ack = 1'b1;
        tick();
        bus2.ack = 1'b0;
        check("t6_idle_ack_txn", bus2.txn_cnt, 2'd0);
        check("t6_idle_ack_done", bus2.done, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus2.start = 1'b1;
            tick();
            bus2.start = 1'b0;
            bus2.ack = 1'b1;
            tick();
            bus2.ack = 1'b0;
            ticks(3);
            check("t6_ready", bus2.ready, 1'b1);
            bus2.ack = 1'b1;
            tick();
            bus2.ack = 1'b0;
            check("t6_txn", bus2.txn_cnt, wrap_exp[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
